// File: rtl/priority_decoder8_reg_if.sv
// priority_decoder8_reg_if
//   Groups the handshake, decode and bookkeeping signals of the registered
//   3-to-8 priority decoder into one bundle.
//
//   Upstream token side : in_valid, in_ready, in_idx[2:0], in_nz
//   Downstream side     : out_valid, out_ready, out_onehot[7:0], out_therm[7:0]
//   Bookkeeping         : acc_vec[7:0], acc_clr, tok_cnt[CNT_W-1:0], err
//
//   master : the environment (drives the token, out_ready and acc_clr)
//   slave  : the decoder itself
interface priority_decoder8_reg_if #(
  parameter int CNT_W = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_idx;
  logic             in_nz;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_onehot;
  logic [7:0]       out_therm;
  logic [7:0]       acc_vec;
  logic             acc_clr;
  logic [CNT_W-1:0] tok_cnt;
  logic             err;

  modport master (
    output in_valid, in_idx, in_nz, out_ready, acc_clr,
    input  in_ready, out_valid, out_onehot, out_therm, acc_vec, tok_cnt, err
  );

  modport slave (
    input  in_valid, in_idx, in_nz, out_ready, acc_clr,
    output in_ready, out_valid, out_onehot, out_therm, acc_vec, tok_cnt, err
  );

endinterface

// File: rtl/priority_decoder8_reg.sv
// priority_decoder8_reg
//   Registered 3-to-8 decoder sitting downstream of an 8:3 priority encoder.
//   Each accepted token (index + nonzero flag) is turned into a one-hot and a
//   thermometer mask held in a 1-deep output register, while a sticky vector
//   accumulates every index seen and a saturating counter counts tokens.
//
//   Ports:
//     clk  - clock, all state updates on the rising edge
//     rst  - asynchronous, active-high reset
//     bus  - priority_decoder8_reg_if.slave (token in, decoded token out,
//            accumulator, clear, token counter, sticky error)
module priority_decoder8_reg #(
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  priority_decoder8_reg_if.slave bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CntMax = '1;

  state_t           r_state;
  state_t           w_nextState;
  logic [7:0]       r_onehot;
  logic [7:0]       r_therm;
  logic [7:0]       r_accVec;
  logic [CNT_W-1:0] r_tokCnt;
  logic             r_err;
  logic             r_stalled;

  logic             w_outValid;
  logic             w_inReady;
  logic             w_accept;
  logic [7:0]       w_onehot;
  logic [7:0]       w_therm;
  logic [7:0]       w_accBase;
  logic [CNT_W-1:0] w_cntBase;
  logic             w_idxUnknown;
  logic             w_dropErr;

  // The output register is valid exactly while the FSM is FULL; the block can
  // take a new token whenever the held one is absent or leaving this cycle,
  // which gives full throughput with a single register stage.
  assign w_outValid = (r_state == FULL);
  assign w_inReady  = !w_outValid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_inReady;

  // Decode the incoming index. Everything is gated by in_nz so an unknown
  // index on an all-zero token never reaches the registers. The thermometer
  // is the one-hot OR'd with every bit below it (onehot-1), which yields
  // 8'hFF for index 7 without needing a wider intermediate.
  always_comb begin
    w_onehot = '0;
    w_therm  = '0;
    if (bus.in_nz) begin
      w_onehot = 8'd1 << bus.in_idx;
      w_therm  = w_onehot | (w_onehot - 8'd1);
    end
  end

  // Clear takes effect before the same-edge token is folded in, so the
  // accumulator and counter restart from zero rather than being wiped of the
  // token that arrived together with the clear.
  always_comb begin
    w_accBase = bus.acc_clr ? 8'd0 : r_accVec;
    w_cntBase = bus.acc_clr ? '0 : r_tokCnt;
  end

  // Protocol checks: an unknown index on a real (nonzero) token only shows up
  // in four-state simulation, and a token that was stalled on the previous
  // edge must still be offered now since no transfer took it.
  always_comb begin
    w_idxUnknown = bus.in_valid && bus.in_nz && $isunknown(bus.in_idx);
    w_dropErr    = r_stalled && !bus.in_valid;
  end

  // FSM next-state: a fresh accept always leaves the register FULL (including
  // back-to-back reloads); otherwise a consumed token empties it and a stalled
  // one holds.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      EMPTY: begin
        if (w_accept) w_nextState = FULL;
      end
      FULL: begin
        if (w_accept)           w_nextState = FULL;
        else if (bus.out_ready) w_nextState = EMPTY;
      end
      default: w_nextState = EMPTY;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= EMPTY;
    else     r_state <= w_nextState;
  end

  // Output data registers only load on an accept, so they stay stable during
  // back-pressure and keep their last values while EMPTY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_onehot <= '0;
      r_therm  <= '0;
    end else if (w_accept) begin
      r_onehot <= w_onehot;
      r_therm  <= w_therm;
    end
  end

  // Accumulator and saturating token counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_accVec <= '0;
      r_tokCnt <= '0;
    end else begin
      r_accVec <= w_accBase | (w_accept ? w_onehot : 8'd0);
      if (w_accept && (w_cntBase != CntMax)) r_tokCnt <= w_cntBase + 1'b1;
      else                                   r_tokCnt <= w_cntBase;
    end
  end

  // Sticky error flag plus the one-cycle memory of a stalled upstream token
  // that the drop check relies on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err     <= 1'b0;
      r_stalled <= 1'b0;
    end else begin
      r_stalled <= bus.in_valid && !w_inReady;
      if (w_idxUnknown || w_dropErr) r_err <= 1'b1;
    end
  end

  assign bus.in_ready   = w_inReady;
  assign bus.out_valid  = w_outValid;
  assign bus.out_onehot = r_onehot;
  assign bus.out_therm  = r_therm;
  assign bus.acc_vec    = r_accVec;
  assign bus.tok_cnt    = r_tokCnt;
  assign bus.err        = r_err;

endmodule

// File: tb/tb_priority_decoder8_reg.sv
// tb_priority_decoder8_reg
//   Self-checking bench for priority_decoder8_reg. Expected output tokens are
//   queued when the bench drives an accept and compared while the DUT holds
//   them; accumulator, counter, handshake and error flag follow a small
//   behavioural model. A second instance with CNT_W=2 covers saturation.
module tb_priority_decoder8_reg;

  typedef struct packed {
    logic [7:0] onehot;
    logic [7:0] therm;
  } token_t;

  logic clk = 1'b0;
  logic rst;
  int   testsRun    = 0;
  int   testsFailed = 0;

  token_t     expQ[$];
  bit         mOutValid;
  logic [7:0] mAcc;
  int         mCnt;
  bit         mErr;
  bit         mStalled;
  int         smallCnt;

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  priority_decoder8_reg_if #(.CNT_W(8)) busMain ();
  priority_decoder8_reg_if #(.CNT_W(2)) busSmall ();

  priority_decoder8_reg #(.CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (busMain)
  );

  priority_decoder8_reg #(.CNT_W(2)) dutSmall (
    .clk (clk),
    .rst (rst),
    .bus (busSmall)
  );

  // Single point of comparison: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic resetModel();
    mOutValid = 1'b0;
    mAcc      = 8'h00;
    mCnt      = 0;
    mErr      = 1'b0;
    mStalled  = 1'b0;
    smallCnt  = 0;
    expQ.delete();
  endtask

  // Drives one cycle of stimulus on the main instance starting at a falling
  // edge, checks the held token and handshake before the rising edge, steps
  // the model, and checks the registered state at the next falling edge.
  task automatic applyStimulus(input logic v, input logic [2:0] idx,
                               input logic nz, input logic ordy,
                               input logic clr);
    token_t tok;
    bit     accept;
    bit     mInReady;
    busMain.in_valid  = v;
    busMain.in_idx    = idx;
    busMain.in_nz     = nz;
    busMain.out_ready = ordy;
    busMain.acc_clr   = clr;
    #1;
    mInReady = !mOutValid || ordy;
    checkOutput("in_ready", {31'd0, busMain.in_ready}, {31'd0, mInReady});
    if (mOutValid) begin
      checkOutput("sb_depth", expQ.size(), 1);
      if (expQ.size() > 0) begin
        checkOutput("out_onehot", {24'd0, busMain.out_onehot}, {24'd0, expQ[0].onehot});
        checkOutput("out_therm", {24'd0, busMain.out_therm}, {24'd0, expQ[0].therm});
        if (ordy) void'(expQ.pop_front());
      end
    end
    accept = v && mInReady;
    if (mStalled && !v) mErr = 1'b1;
    mStalled = v && !mInReady;
    if (clr) begin
      mAcc = 8'h00;
      mCnt = 0;
    end
    if (accept) begin
      for (int b = 0; b < 8; b++) begin
        tok.onehot[b] = nz && (b == int'(idx));
        tok.therm[b]  = nz && (b <= int'(idx));
      end
      expQ.push_back(tok);
      mAcc = mAcc | tok.onehot;
      if (mCnt < 255) mCnt++;
      mOutValid = 1'b1;
    end else if (ordy) begin
      mOutValid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput("out_valid", {31'd0, busMain.out_valid}, {31'd0, mOutValid});
    checkOutput("acc_vec", {24'd0, busMain.acc_vec}, {24'd0, mAcc});
    checkOutput("tok_cnt", {24'd0, busMain.tok_cnt}, mCnt);
    checkOutput("err", {31'd0, busMain.err}, {31'd0, mErr});
  endtask

  // One always-ready accept on the CNT_W=2 instance.
  task automatic smallStep(input logic [2:0] idx);
    busSmall.in_valid  = 1'b1;
    busSmall.in_idx    = idx;
    busSmall.in_nz     = 1'b1;
    busSmall.out_ready = 1'b1;
    busSmall.acc_clr   = 1'b0;
    if (smallCnt < 3) smallCnt++;
    @(posedge clk);
    @(negedge clk);
    checkOutput("small_tok_cnt", {30'd0, busSmall.tok_cnt}, smallCnt);
  endtask

  initial begin
    rst = 1'b1;
    busMain.in_valid   = 1'b0;
    busMain.in_idx     = 3'd0;
    busMain.in_nz      = 1'b0;
    busMain.out_ready  = 1'b0;
    busMain.acc_clr    = 1'b0;
    busSmall.in_valid  = 1'b0;
    busSmall.in_idx    = 3'd0;
    busSmall.in_nz     = 1'b0;
    busSmall.out_ready = 1'b0;
    busSmall.acc_clr   = 1'b0;
    resetModel();

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", {31'd0, busMain.out_valid}, 0);
    checkOutput("rst_onehot", {24'd0, busMain.out_onehot}, 0);
    checkOutput("rst_therm", {24'd0, busMain.out_therm}, 0);
    checkOutput("rst_acc_vec", {24'd0, busMain.acc_vec}, 0);
    checkOutput("rst_tok_cnt", {24'd0, busMain.tok_cnt}, 0);
    checkOutput("rst_err", {31'd0, busMain.err}, 0);
    checkOutput("rst_small_cnt", {30'd0, busSmall.tok_cnt}, 0);
    rst = 1'b0;
    #1;
    checkOutput("rst_in_ready", {31'd0, busMain.in_ready}, 1);
    @(negedge clk);

    // Single token idx=5.
    applyStimulus(1'b1, 3'd5, 1'b1, 1'b1, 1'b0);
    checkOutput("t1_onehot", {24'd0, busMain.out_onehot}, 32'h20);
    checkOutput("t1_therm", {24'd0, busMain.out_therm}, 32'h3F);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);

    // Back-to-back stream 0..7, after clearing the accumulator.
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 3'(i), 1'b1, 1'b1, 1'b0);
    checkOutput("stream_acc", {24'd0, busMain.acc_vec}, 32'hFF);
    checkOutput("stream_cnt", {24'd0, busMain.tok_cnt}, 8);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);

    // Back-pressure: idx=3 held while idx=6 waits, then released.
    applyStimulus(1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 3'd6, 1'b1, 1'b0, 1'b0);
    checkOutput("stall_onehot", {24'd0, busMain.out_onehot}, 32'h08);
    applyStimulus(1'b1, 3'd6, 1'b1, 1'b1, 1'b0);
    checkOutput("release_onehot", {24'd0, busMain.out_onehot}, 32'h40);
    checkOutput("release_therm", {24'd0, busMain.out_therm}, 32'h7F);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);

    // All-zero token with an unknown index.
    applyStimulus(1'b1, 3'bxxx, 1'b0, 1'b1, 1'b0);
    checkOutput("nz0_onehot", {24'd0, busMain.out_onehot}, 0);
    checkOutput("nz0_err", {31'd0, busMain.err}, 0);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);

    // Clear coinciding with an accept.
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
    for (int i = 4; i < 8; i++) applyStimulus(1'b1, 3'(i), 1'b1, 1'b1, 1'b0);
    checkOutput("pre_clr_acc", {24'd0, busMain.acc_vec}, 32'hF0);
    applyStimulus(1'b1, 3'd2, 1'b1, 1'b1, 1'b1);
    checkOutput("clr_acc", {24'd0, busMain.acc_vec}, 32'h04);
    checkOutput("clr_cnt", {24'd0, busMain.tok_cnt}, 1);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);

    // Counter saturation on the narrow instance.
    for (int i = 0; i < 5; i++) smallStep(3'(i));
    busSmall.in_valid = 1'b0;
    checkOutput("small_sat", {30'd0, busSmall.tok_cnt}, 3);

    // Asynchronous reset while FULL.
    applyStimulus(1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
    busMain.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_out_valid", {31'd0, busMain.out_valid}, 0);
    checkOutput("arst_acc_vec", {24'd0, busMain.acc_vec}, 0);
    @(negedge clk);
    rst = 1'b0;
    resetModel();
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);

    // Upstream drops a stalled token.
    applyStimulus(1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
    checkOutput("pre_drop_err", {31'd0, busMain.err}, 0);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("drop_err", {31'd0, busMain.err}, 1);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("err_sticky", {31'd0, busMain.err}, 1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
